// File: rtl/alu_seq_pkg.sv
// Shared types for the iterative-ALU step sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/iter_sequencer.sv
// Sequences an external up/down step counter: clear, n_iter count pulses, done.
// Latency: CLEAR one cycle after accept, RUN for n_iter cycles, done at n_iter+2.
// Backpressure: ready is high only in IDLE; a start while busy is dropped, not queued.
module iter_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] n_iter,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt,
    output logic             cnt_rst,
    output logic             count_up,
    output logic             count_down,
    output logic             ready,
    output logic             ld_en,
    output logic             step_en,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    state_t           state_q;
    state_t           state_d;
    logic             dir_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] target_d;
    logic             cnt_rst_q;
    logic             first_run_q;
    logic             accept;

    assign accept = start && (state_q == IDLE);

    // The counter reads back the number of completed steps, so the last step is
    // the RUN cycle where cnt equals n_iter-1 (up) or its negation (down).
    assign target_d = (dir == DIR_DOWN) ? (WIDTH'(1) - n_iter) : (n_iter - WIDTH'(1));

    assign ready   = (state_q == IDLE);
    assign cnt_rst = cnt_rst_q;

    // State register plus the registered counter clear and first-RUN marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_rst_q   <= 1'b0;
            first_run_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Decoded from next state so the counter reset line is a clean flop output.
            cnt_rst_q   <= (state_d == CLEAR);
            first_run_q <= (state_q == CLEAR) && (state_d == RUN);
        end
    end

    // Op parameters captured once on accept; ignored for the rest of the op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q    <= DIR_UP;
            target_q <= '0;
        end else if (accept) begin
            dir_q    <= dir;
            target_q <= target_d;
        end
    end

    // Next-state decode and per-cycle control outputs.
    always_comb begin
        state_d    = state_q;
        count_up   = 1'b0;
        count_down = 1'b0;
        ld_en      = 1'b0;
        step_en    = 1'b0;
        done       = 1'b0;
        aborted    = 1'b0;
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (n_iter == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                ld_en = 1'b1;
                if (abort) begin
                    aborted = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (abort) begin
                    // Abort takes priority over both the last step and the check.
                    aborted = 1'b1;
                    state_d = IDLE;
                end else if (first_run_q && (cnt != '0)) begin
                    // Counter failed to clear: stop without touching it.
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    count_up   = (dir_q == DIR_UP);
                    count_down = (dir_q == DIR_DOWN);
                    if (cnt == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iter_sequencer.sv
// Bench for iter_sequencer paired with a behavioural step counter.
// Latency: op outcome predicted per accept and checked when the DUT reports it.
// Backpressure: driver only issues ops when ready; random starts while busy must be dropped.
module tb_iter_sequencer;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] n_iter = '0;
    logic [W-1:0] cnt;
    logic         cnt_rst, count_up, count_down, ready, ld_en, step_en, done, aborted, err;

    logic         block_rst = 1'b0;
    logic         preload_vld = 1'b0;
    logic [W-1:0] preload_val = '0;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int model_cnt = 0;

    typedef enum int {K_DONE = 0, K_ERR = 1, K_ABORT = 2} kind_t;
    typedef struct {
        kind_t kind;
        int    t0;
        bit    dir;
        int    at;
        int    cnt_v;
        int    ups;
        int    downs;
        int    rsts;
        int    lds;
    } exp_t;

    exp_t sb[$];

    iter_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dir        (dir),
        .n_iter     (n_iter),
        .abort      (abort),
        .cnt        (cnt),
        .cnt_rst    (cnt_rst),
        .count_up   (count_up),
        .count_down (count_down),
        .ready      (ready),
        .ld_en      (ld_en),
        .step_en    (step_en),
        .done       (done),
        .aborted    (aborted),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural partner counter; block_rst lets the bench defeat the clear.
    always @(posedge clk or posedge reset) begin
        if (reset)                       cnt <= '0;
        else if (cnt_rst && !block_rst)  cnt <= '0;
        else if (preload_vld)            cnt <= preload_val;
        else if (count_up)               cnt <= cnt + 1'b1;
        else if (count_down)             cnt <= cnt - 1'b1;
    end

    function automatic int wrap(input int v);
        return v & ((1 << W) - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples after the driver has settled inputs for this cycle.
    int acc_up = 0, acc_dn = 0, acc_rst = 0, acc_ld = 0;
    bit ready_chk = 0;
    always @(negedge clk) begin
        exp_t  e;
        kind_t kact;
        int    j;
        #2;
        if (reset) begin
            sb.delete();
            acc_up = 0; acc_dn = 0; acc_rst = 0; acc_ld = 0;
            ready_chk = 0;
        end else begin
            if (ready_chk) begin
                check("ready_after_end", int'(ready), 1);
                ready_chk = 0;
            end
            if (count_up)   acc_up++;
            if (count_down) acc_dn++;
            if (cnt_rst)    acc_rst++;
            if (ld_en)      acc_ld++;
            if (step_en) begin
                check("up_down_exclusive", int'(count_up & count_down), 0);
                if (sb.size() > 0 && sb[0].kind != K_ERR) begin
                    j = cyc - sb[0].t0 - 2;
                    check("run_cnt", int'(cnt), wrap(sb[0].dir ? -j : j));
                end
            end
            if (done || err || aborted) begin
                check("one_outcome", int'(done) + int'(err) + int'(aborted), 1);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_outcome: got done=%0d err=%0d aborted=%0d, none expected (cycle %0d)",
                             done, err, aborted, cyc);
                end else begin
                    e = sb.pop_front();
                    kact = done ? K_DONE : (err ? K_ERR : K_ABORT);
                    check("outcome_kind", int'(kact), int'(e.kind));
                    check("outcome_cycle", cyc - e.t0, e.at);
                    check("final_cnt", int'(cnt), e.cnt_v);
                    check("up_pulses", acc_up, e.ups);
                    check("down_pulses", acc_dn, e.downs);
                    check("cnt_rst_pulses", acc_rst, e.rsts);
                    check("ld_en_pulses", acc_ld, e.lds);
                end
                acc_up = 0; acc_dn = 0; acc_rst = 0; acc_ld = 0;
                ready_chk = 1;
            end
        end
    end

    // Issue one op at a negedge where ready=1; returns at the negedge ready is seen again.
    // a = RUN cycle (1-based) in which to raise abort, 0 for none.
    task automatic run_op(input bit d, input int n, input int a, input bit err_mode);
        exp_t e;
        int   steps;
        bit   seen;
        check("ready_before_op", int'(ready), 1);
        start  = 1'b1;
        dir    = d;
        n_iter = n[W-1:0];
        abort  = 1'($urandom_range(0, 1));
        e.t0 = cyc;
        e.dir = d;
        steps = 0;
        if (err_mode) begin
            e.kind = K_ERR; e.at = 2; e.cnt_v = model_cnt;
            e.ups = 0; e.downs = 0; e.rsts = 1; e.lds = 1;
        end else if (n == 0) begin
            e.kind = K_DONE; e.at = 1; e.cnt_v = model_cnt;
            e.ups = 0; e.downs = 0; e.rsts = 0; e.lds = 0;
        end else begin
            if (a >= 1 && a <= n) begin
                e.kind = K_ABORT; e.at = 1 + a; steps = a - 1;
            end else begin
                e.kind = K_DONE; e.at = n + 2; steps = n;
            end
            e.cnt_v = wrap(d ? -steps : steps);
            e.ups = d ? 0 : steps;
            e.downs = d ? steps : 0;
            e.rsts = 1;
            e.lds = 1;
        end
        model_cnt = e.cnt_v;
        sb.push_back(e);
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (ready) begin
                seen  = 1;
                start = 1'b0;
                abort = 1'b0;
            end else begin
                start  = 1'($urandom_range(0, 1));
                dir    = 1'($urandom_range(0, 1));
                n_iter = W'($urandom_range(0, (1 << W) - 1));
                abort  = (a >= 1 && k == 1 + a);
            end
        end
        if (!seen) check("op_timeout", 0, 1);
    endtask

    initial begin
        int d, n, a;
        #2;
        check("reset_ready", int'(ready), 1);
        check("reset_outputs",
              int'({cnt_rst, count_up, count_down, ld_en, step_en, done, aborted, err}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 5, 0, 1'b0);
        run_op(1'b1, 3, 0, 1'b0);
        run_op(1'b0, 0, 0, 1'b0);
        run_op(1'b0, 7, 0, 1'b0);
        run_op(1'b0, 7, 3, 1'b0);

        // Counter clear defeated and preloaded: first RUN must flag err.
        block_rst   = 1'b1;
        preload_vld = 1'b1;
        preload_val = 3'd3;
        @(negedge clk);
        preload_vld = 1'b0;
        model_cnt   = 3;
        run_op(1'b0, 4, 0, 1'b1);
        block_rst = 1'b0;

        // Async reset in the middle of RUN.
        start = 1'b1; dir = 1'b0; n_iter = 3'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #3;
        check("midrun_step_en", int'(step_en), 1);
        reset = 1'b1;
        #1;
        check("async_reset_ready", int'(ready), 1);
        check("async_reset_outputs",
              int'({cnt_rst, count_up, count_down, ld_en, step_en, done, aborted, err}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        check("ready_after_reset", int'(ready), 1);
        check("cnt_after_reset", int'(cnt), 0);

        for (int i = 0; i < 80; i++) begin
            d = $urandom_range(0, 1);
            n = $urandom_range(0, (1 << W) - 1);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : 0;
            run_op(1'(d), n, a, 1'b0);
        end

        repeat (4) @(negedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
